sdram_arb_n: RTL and testbench
==============================

Name: sdram_arb_n

Overview:
N-port request arbiter that shares one sdram32 core request interface (wr/rd/addr/write_data/accept/ack/error/read_data) among NUM_PORTS masters. It generalises the fixed two-port arbiter to N ports with round-robin grant and ordered ack routing through a tag FIFO, so multiple requests can be outstanding at the core. It sits between the per-master adapters (AXI pmem bridge, gated direct-port bridge, others) and the sdram32 core, all on the SDRAM clock.

Parameters:
NUM_PORTS, 2, number of master ports (2..8)
ADDR_W, 32, request address width
DATA_W, 32, data width; byte-strobe width WR_W = DATA_W/8
MAX_OUTSTANDING, 4, depth of the in-flight tag FIFO (power of 2, >=1)

Ports:
clk_i  in  1  SDRAM-domain clock; all logic on rising edge
rst_i  in  1  synchronous active-high reset
port_wr_i  in  NUM_PORTS*WR_W  per-port byte write strobes, port p at [p*WR_W +: WR_W]
port_rd_i  in  NUM_PORTS  per-port read request
port_len_i  in  NUM_PORTS*8  per-port burst length minus 1 (used only with SDRAM_ARB_BURST_LOCK_EN)
port_addr_i  in  NUM_PORTS*ADDR_W  per-port address
port_write_data_i  in  NUM_PORTS*DATA_W  per-port write data
port_accept_o  out  NUM_PORTS  request accepted this cycle (one-hot or zero)
port_ack_o  out  NUM_PORTS  response for the port's oldest outstanding request (one-hot or zero)
port_error_o  out  NUM_PORTS  error qualifier, valid with port_ack_o
port_read_data_o  out  DATA_W  read data, broadcast to all ports, valid with port_ack_o
core_wr_o  out  WR_W  to core
core_rd_o  out  1  to core
core_addr_o  out  ADDR_W  to core
core_write_data_o  out  DATA_W  to core
core_accept_i  in  1  core accepted presented request
core_ack_i  in  1  core response valid
core_error_i  in  1  core response error
core_read_data_i  in  DATA_W  core read data
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  requests in flight
unexpected_ack_o  out  1  one-cycle pulse: core_ack_i arrived with FIFO empty

Behaviour:
- Port request req[p] = |port_wr_i[p] | port_rd_i[p]; a master holds its request and payload stable until port_accept_o[p].
- State GRANT_IDLE: if any req and FIFO not full, grant = first requesting port at or after rr_ptr (wrapping modulo NUM_PORTS); go GRANT_HOLD with grant registered. Selection and first presentation occur in the same cycle.
- GRANT_HOLD: core_* = granted port's payload. A presented request is never withdrawn or switched before core_accept_i, even if a higher-rotation port asserts.
- On accept (core_accept_i & presented & !fifo_full): port_accept_o[grant]=1, push grant id into tag FIFO, rr_ptr <= grant+1 (wrap NUM_PORTS-1 -> 0), return to GRANT_IDLE; next grant decision in the following cycle.
- FIFO full: core_wr_o=0, core_rd_o=0, no accept. An ack in the same cycle does not free a slot for that cycle; pop then push is allowed from the next cycle.
- No request: core_wr_o/core_rd_o = 0; addr/data hold last value.
- core_ack_i with FIFO non-empty: pop head; port_ack_o[head]=1, port_error_o[head]=core_error_i, combinational from core_ack_i (0-cycle latency). Push and pop in the same cycle keep outstanding_o unchanged.
- core_ack_i with FIFO empty: dropped; unexpected_ack_o=1 for 1 cycle; no port ack.
- Reset (also mid-transfer): rr_ptr=0, FIFO empty, outstanding_o=0, state GRANT_IDLE, all port_*_o, core_wr_o, core_rd_o and unexpected_ack_o = 0, core_addr_o/core_write_data_o = 0. In-flight acks after reset count as unexpected.

Optional Feature:
SDRAM_ARB_BURST_LOCK_EN: when defined, on a grant from GRANT_IDLE the arbiter loads beat_cnt = port_len_i[grant] and stays locked to that port for beat_cnt+1 accepted requests; rr_ptr advances only after the final beat. A locked port dropping its request leaves the lock held (core_wr_o/core_rd_o = 0) until the remaining beats are accepted. When not defined, port_len_i is ignored and every accept re-arbitrates.

Test Plan:
- Reset, then port0 read addr 0x100, core_accept 1 cycle later, ack 3 cycles later with data 0xDEADBEEF -> port_accept_o=01 once, port_ack_o=01 once, read_data 0xDEADBEEF, outstanding 0->1->0.
- NUM_PORTS=4, all ports request continuously, core_accept always 1 -> accept order 0,1,2,3,0,1..., each port exactly 25% of 400 accepts.
- core_accept_i held 0 for 5 cycles while port1 requests and port0 joins -> core_addr_o stays port1's address, port0 not granted until port1 accepted.
- 4 accepts (ports 2,0,3,2) with no acks, 5th request -> core_rd_o=0, no accept; then 4 acks -> port_ack_o sequence 0100,0001,1000,0100, error forwarded when core_error_i=1 on the 2nd ack.
- core_ack_i with nothing outstanding -> unexpected_ack_o pulses 1 cycle, port_ack_o=0; rst_i mid-burst with 2 outstanding -> outstanding_o=0 next cycle.
- With SDRAM_ARB_BURST_LOCK_EN, port1 len=3, port0 requesting -> 4 consecutive port1 accepts before port0 granted.

Source files
------------

// File: rtl/sdram_arb_n_if.sv
// sdram_arb_n_if: bundles the per-port master buses and the shared sdram32 core
// request/response bus that the N-port arbiter sits between.
// The slave modport is the arbiter's view; the master modport is the view of
// whoever drives the ports and models the core.
interface sdram_arb_n_if #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int WR_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  // Master-side request buses, one slice per port
  logic [NUM_PORTS*WR_W-1:0]   port_wr_i;
  logic [NUM_PORTS-1:0]        port_rd_i;
  logic [NUM_PORTS*8-1:0]      port_len_i;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr_i;
  logic [NUM_PORTS*DATA_W-1:0] port_write_data_i;
  logic [NUM_PORTS-1:0]        port_accept_o;
  logic [NUM_PORTS-1:0]        port_ack_o;
  logic [NUM_PORTS-1:0]        port_error_o;
  logic [DATA_W-1:0]           port_read_data_o;

  // Shared core bus
  logic [WR_W-1:0]             core_wr_o;
  logic                        core_rd_o;
  logic [ADDR_W-1:0]           core_addr_o;
  logic [DATA_W-1:0]           core_write_data_o;
  logic                        core_accept_i;
  logic                        core_ack_i;
  logic                        core_error_i;
  logic [DATA_W-1:0]           core_read_data_i;

  // Status
  logic [CNT_W-1:0]            outstanding_o;
  logic                        unexpected_ack_o;

  modport slave (
    input  port_wr_i, port_rd_i, port_len_i, port_addr_i, port_write_data_i,
    output port_accept_o, port_ack_o, port_error_o, port_read_data_o,
    output core_wr_o, core_rd_o, core_addr_o, core_write_data_o,
    input  core_accept_i, core_ack_i, core_error_i, core_read_data_i,
    output outstanding_o, unexpected_ack_o
  );

  modport master (
    output port_wr_i, port_rd_i, port_len_i, port_addr_i, port_write_data_i,
    input  port_accept_o, port_ack_o, port_error_o, port_read_data_o,
    input  core_wr_o, core_rd_o, core_addr_o, core_write_data_o,
    output core_accept_i, core_ack_i, core_error_i, core_read_data_i,
    input  outstanding_o, unexpected_ack_o
  );
endinterface

// File: rtl/sdram_arb_n.sv
// sdram_arb_n: round-robin arbiter sharing one sdram32 core request bus among
// NUM_PORTS masters. Granted port ids are queued in a tag FIFO so acks, which
// the core returns in order, are routed back to the right master.
// Optional feature macro: SDRAM_ARB_BURST_LOCK_EN keeps a grant locked to one
// port for port_len_i+1 accepted requests.
module sdram_arb_n #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  sdram_arb_n_if.slave bus
);
  localparam int WR_W  = DATA_W / 8;
  localparam int TAG_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [0:0] {GRANT_IDLE, GRANT_HOLD} state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   grant_q, grant_d;
  logic [TAG_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0]   tag_mem_q [MAX_OUTSTANDING];
  logic [TAG_W-1:0]   tag_mem_d [MAX_OUTSTANDING];
  logic [ADDR_W-1:0]  addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0]  wdata_hold_q, wdata_hold_d;

`ifdef SDRAM_ARB_BURST_LOCK_EN
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic [7:0]         beat_cur;
`else
  logic               unused_len;
  assign unused_len = ^bus.port_len_i;
`endif

  logic [NUM_PORTS-1:0] req;
  logic [TAG_W-1:0]     pick;
  logic                 pick_vld;
  logic [TAG_W-1:0]     cur;
  logic [TAG_W-1:0]     cur_next;
  logic                 presenting;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [TAG_W-1:0]     head;
  logic [NUM_PORTS-1:0] one_hot_1;

  assign one_hot_1  = {{(NUM_PORTS-1){1'b0}}, 1'b1};
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = tag_mem_q[rd_ptr_q];

  // Per-port request: any byte strobe or a read
  always_comb begin
    req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req[p] = (|bus.port_wr_i[p*WR_W +: WR_W]) | bus.port_rd_i[p];
    end
  end

  // Round-robin pick: first requester at or after rr_q, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!pick_vld && req[(int'(rr_q) + i) % NUM_PORTS]) begin
        pick_vld = 1'b1;
        pick     = TAG_W'((int'(rr_q) + i) % NUM_PORTS);
      end
    end
  end

  // Grant FSM next-state, presentation, accept and rotation update
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cur        = grant_q;
    presenting = 1'b0;
    accept     = 1'b0;
`ifdef SDRAM_ARB_BURST_LOCK_EN
    beat_cnt_d = beat_cnt_q;
    beat_cur   = beat_cnt_q;
`endif
    case (state_q)
      GRANT_IDLE: begin
        // Selection and first presentation happen in the same cycle
        if (pick_vld && !fifo_full) begin
          cur        = pick;
          presenting = 1'b1;
          grant_d    = pick;
          state_d    = GRANT_HOLD;
`ifdef SDRAM_ARB_BURST_LOCK_EN
          beat_cur   = bus.port_len_i[int'(pick)*8 +: 8];
          beat_cnt_d = beat_cur;
`endif
        end
      end
      GRANT_HOLD: begin
        cur        = grant_q;
        presenting = req[grant_q] && !fifo_full;
`ifndef SDRAM_ARB_BURST_LOCK_EN
        // A master that abandons its request frees the bus for re-arbitration
        if (!req[grant_q]) state_d = GRANT_IDLE;
`endif
      end
      default: state_d = GRANT_IDLE;
    endcase

    cur_next = (cur == TAG_W'(NUM_PORTS - 1)) ? '0 : cur + 1'b1;
    accept   = presenting && bus.core_accept_i;

    if (accept) begin
`ifdef SDRAM_ARB_BURST_LOCK_EN
      if (beat_cur == 8'd0) begin
        rr_d    = cur_next;
        state_d = GRANT_IDLE;
      end else begin
        beat_cnt_d = beat_cur - 8'd1;
        state_d    = GRANT_HOLD;
      end
`else
      rr_d    = cur_next;
      state_d = GRANT_IDLE;
`endif
    end
  end

  // Tag FIFO bookkeeping and held core address/data
  always_comb begin
    push         = accept;
    pop          = bus.core_ack_i && !fifo_empty;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    addr_hold_d  = addr_hold_q;
    wdata_hold_d = wdata_hold_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = cur;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (presenting) begin
      addr_hold_d  = bus.port_addr_i[int'(cur)*ADDR_W +: ADDR_W];
      wdata_hold_d = bus.port_write_data_i[int'(cur)*DATA_W +: DATA_W];
    end
  end

  // Output drive; everything forced quiet while reset is asserted
  always_comb begin
    bus.core_wr_o         = '0;
    bus.core_rd_o         = 1'b0;
    bus.core_addr_o       = '0;
    bus.core_write_data_o = '0;
    bus.port_accept_o     = '0;
    bus.port_ack_o        = '0;
    bus.port_error_o      = '0;
    bus.port_read_data_o  = '0;
    bus.unexpected_ack_o  = 1'b0;
    if (!rst_i) begin
      bus.core_addr_o       = addr_hold_d;
      bus.core_write_data_o = wdata_hold_d;
      if (presenting) begin
        bus.core_wr_o = bus.port_wr_i[int'(cur)*WR_W +: WR_W];
        bus.core_rd_o = bus.port_rd_i[cur];
      end
      if (accept) bus.port_accept_o = one_hot_1 << cur;
      if (pop) begin
        bus.port_ack_o   = one_hot_1 << head;
        bus.port_error_o = bus.core_error_i ? (one_hot_1 << head) : '0;
      end
      bus.port_read_data_o = bus.core_read_data_i;
      bus.unexpected_ack_o = bus.core_ack_i && fifo_empty;
    end
  end

  assign bus.outstanding_o = cnt_q;

  // Control state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= GRANT_IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
`ifdef SDRAM_ARB_BURST_LOCK_EN
      beat_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
`ifdef SDRAM_ARB_BURST_LOCK_EN
      beat_cnt_q   <= beat_cnt_d;
`endif
    end
  end

  // Tag storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk_i) begin
    tag_mem_q <= tag_mem_d;
  end

endmodule

// File: tb/tb_sdram_arb_n.sv
// tb_sdram_arb_n: directed checks of the 4-port arbiter: single read, fair
// rotation, grant hold under back-pressure, FIFO full, ordered ack routing,
// unexpected acks, mid-transfer reset and (with SDRAM_ARB_BURST_LOCK_EN) burst lock.
module tb_sdram_arb_n;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  int   pc [NP];

  sdram_arb_n_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) bus ();

  sdram_arb_n #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input int p, input logic rd, input logic [31:0] addr);
    bus.port_rd_i[p]          = rd;
    bus.port_addr_i[p*AW +: AW] = addr;
  endtask

  task automatic clear_inputs();
    bus.port_wr_i         = '0;
    bus.port_rd_i         = '0;
    bus.port_len_i        = '0;
    bus.port_addr_i       = '0;
    bus.port_write_data_i = '0;
    bus.core_accept_i     = 1'b0;
    bus.core_ack_i        = 1'b0;
    bus.core_error_i      = 1'b0;
    bus.core_read_data_i  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset state
    do_reset();
    #1;
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_core_rd", bus.core_rd_o, 0);
    chk("rst_core_addr", bus.core_addr_o, 0);
    chk("rst_accept", bus.port_accept_o, 0);
    chk("rst_unexp", bus.unexpected_ack_o, 0);

    // Single read on port0, accept one cycle later, ack three cycles after accept
    set_rd(0, 1'b1, 32'h100);
    #1;
    chk("t1_core_rd", bus.core_rd_o, 1);
    chk("t1_core_addr", bus.core_addr_o, 32'h100);
    chk("t1_no_accept", bus.port_accept_o, 0);
    cyc();
    bus.core_accept_i = 1'b1;
    #1;
    chk("t1_accept", bus.port_accept_o, 4'b0001);
    chk("t1_out0", bus.outstanding_o, 0);
    cyc();
    set_rd(0, 1'b0, 32'h100);
    bus.core_accept_i = 1'b0;
    #1;
    chk("t1_accept_once", bus.port_accept_o, 0);
    chk("t1_out1", bus.outstanding_o, 1);
    chk("t1_idle_rd", bus.core_rd_o, 0);
    chk("t1_addr_hold", bus.core_addr_o, 32'h100);
    cyc();
    cyc();
    bus.core_ack_i       = 1'b1;
    bus.core_read_data_i = 32'hDEADBEEF;
    #1;
    chk("t1_ack", bus.port_ack_o, 4'b0001);
    chk("t1_rdata", bus.port_read_data_o, 32'hDEADBEEF);
    chk("t1_err", bus.port_error_o, 0);
    chk("t1_unexp", bus.unexpected_ack_o, 0);
    cyc();
    bus.core_ack_i = 1'b0;
    #1;
    chk("t1_ack_once", bus.port_ack_o, 0);
    chk("t1_out_back0", bus.outstanding_o, 0);

    // Fairness: all ports request, core accepts and acks every cycle
    do_reset();
    for (int p = 0; p < NP; p++) begin
      set_rd(p, 1'b1, 32'h1000 + 32'(p));
      pc[p] = 0;
    end
    bus.core_accept_i = 1'b1;
    bus.core_ack_i    = 1'b1;
    for (int k = 0; k < 400; k++) begin
      #1;
      chk("t2_order", bus.port_accept_o, 64'(4'b0001 << (k % NP)));
      if (k > 0) chk("t2_ack_order", bus.port_ack_o, 64'(4'b0001 << ((k - 1) % NP)));
      for (int p = 0; p < NP; p++) if (bus.port_accept_o[p]) pc[p]++;
      cyc();
    end
    clear_inputs();
    for (int p = 0; p < NP; p++) chk("t2_share", 64'(pc[p]), 100);
    #1;
    chk("t2_out_tail", bus.outstanding_o, 1);

    // Back-pressure: port1 presented, port0 joins, grant must not switch
    do_reset();
    set_rd(1, 1'b1, 32'h200);
    #1;
    chk("t3_first_addr", bus.core_addr_o, 32'h200);
    chk("t3_first_rd", bus.core_rd_o, 1);
    cyc();
    set_rd(0, 1'b1, 32'h300);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_hold_addr", bus.core_addr_o, 32'h200);
      chk("t3_hold_noacc", bus.port_accept_o, 0);
      cyc();
    end
    bus.core_accept_i = 1'b1;
    #1;
    chk("t3_acc_p1", bus.port_accept_o, 4'b0010);
    cyc();
    set_rd(1, 1'b0, 32'h200);
    #1;
    chk("t3_acc_p0", bus.port_accept_o, 4'b0001);
    chk("t3_addr_p0", bus.core_addr_o, 32'h300);
    cyc();
    set_rd(0, 1'b0, 32'h300);
    bus.core_accept_i = 1'b0;
    #1;
    chk("t3_out2", bus.outstanding_o, 2);

    // Reset with two requests in flight, then a stale ack
    rst = 1'b1;
    #1;
    chk("t5_rst_noacc", bus.port_accept_o, 0);
    cyc();
    #1;
    chk("t5_rst_out0", bus.outstanding_o, 0);
    rst = 1'b0;
    bus.core_ack_i = 1'b1;
    #1;
    chk("t5_stale_unexp", bus.unexpected_ack_o, 1);
    chk("t5_stale_noack", bus.port_ack_o, 0);
    cyc();
    bus.core_ack_i = 1'b0;

    // FIFO full after accepts from ports 2,0,3,2; then ordered acks
    do_reset();
    bus.core_accept_i = 1'b1;
    set_rd(2, 1'b1, 32'h400);
    #1; chk("t4_acc_a", bus.port_accept_o, 4'b0100);
    cyc(); set_rd(2, 1'b0, 0); set_rd(0, 1'b1, 32'h410);
    #1; chk("t4_acc_b", bus.port_accept_o, 4'b0001);
    cyc(); set_rd(0, 1'b0, 0); set_rd(3, 1'b1, 32'h420);
    #1; chk("t4_acc_c", bus.port_accept_o, 4'b1000);
    cyc(); set_rd(3, 1'b0, 0); set_rd(2, 1'b1, 32'h430);
    #1; chk("t4_acc_d", bus.port_accept_o, 4'b0100);
    cyc(); set_rd(2, 1'b0, 0); set_rd(1, 1'b1, 32'h440);
    #1;
    chk("t4_full_out", bus.outstanding_o, 4);
    chk("t4_full_rd", bus.core_rd_o, 0);
    chk("t4_full_noacc", bus.port_accept_o, 0);
    cyc();
    bus.core_ack_i = 1'b1;
    #1;
    chk("t4_ack1", bus.port_ack_o, 4'b0100);
    chk("t4_ack1_err", bus.port_error_o, 0);
    chk("t4_ack_nofree_rd", bus.core_rd_o, 0);
    chk("t4_ack_nofree_acc", bus.port_accept_o, 0);
    cyc();
    set_rd(1, 1'b0, 0);
    bus.core_accept_i = 1'b0;
    bus.core_error_i  = 1'b1;
    #1;
    chk("t4_ack2", bus.port_ack_o, 4'b0001);
    chk("t4_ack2_err", bus.port_error_o, 4'b0001);
    cyc();
    bus.core_error_i = 1'b0;
    #1;
    chk("t4_ack3", bus.port_ack_o, 4'b1000);
    chk("t4_ack3_err", bus.port_error_o, 0);
    cyc();
    #1;
    chk("t4_ack4", bus.port_ack_o, 4'b0100);
    cyc();
    bus.core_ack_i = 1'b0;
    #1;
    chk("t4_out0", bus.outstanding_o, 0);

    // Ack with nothing outstanding
    bus.core_ack_i = 1'b1;
    #1;
    chk("t5_unexp", bus.unexpected_ack_o, 1);
    chk("t5_unexp_noack", bus.port_ack_o, 0);
    cyc();
    bus.core_ack_i = 1'b0;
    #1;
    chk("t5_unexp_pulse", bus.unexpected_ack_o, 0);

`ifdef SDRAM_ARB_BURST_LOCK_EN
    // Burst lock: port1 len=3 holds the bus for four accepts before port0
    do_reset();
    bus.port_len_i[1*8 +: 8] = 8'd3;
    bus.core_accept_i = 1'b1;
    bus.core_ack_i    = 1'b1;
    set_rd(1, 1'b1, 32'h500);
    #1;
    chk("t6_beat0", bus.port_accept_o, 4'b0010);
    cyc();
    set_rd(0, 1'b1, 32'h600);
    for (int k = 1; k < 4; k++) begin
      #1;
      chk("t6_beat", bus.port_accept_o, 4'b0010);
      cyc();
    end
    set_rd(1, 1'b0, 0);
    #1;
    chk("t6_p0_after", bus.port_accept_o, 4'b0001);
    cyc();
    clear_inputs();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // Global time bound so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
